// File: rtl/fphub_pkg.sv
// fphub_pkg: special-case codes and magnitude patterns shared by the FPHUB multiplier blocks.
package fphub_pkg;

    typedef enum logic [2:0] {
        CASE_NONE   = 3'd0,
        CASE_INF_P  = 3'd1,
        CASE_INF_N  = 3'd2,
        CASE_ZERO_P = 3'd3,
        CASE_ZERO_N = 3'd4,
        CASE_ONE_P  = 3'd5,
        CASE_ONE_N  = 3'd6
    } special_case_t;

    localparam int SPECIAL_CASES = 7;

    // FPHUB infinity is the all-ones magnitude, not IEEE exp-all-ones/mant-zero.
    function automatic logic [63:0] fphub_inf(input int e, input int m);
        return (64'd1 << (e + m)) - 64'd1;
    endfunction

    function automatic logic [63:0] fphub_one(input int e, input int m);
        return 64'd1 << (e + m - 1);
    endfunction

endpackage

// File: rtl/fphub_special_classify.sv
// fphub_special_classify: maps one FPHUB operand onto its special-case code.
module fphub_special_classify
    import fphub_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [E+M:0]   op,
    output special_case_t  code
);

    localparam int MW = E + M;
    localparam logic [MW-1:0] INF = MW'(fphub_inf(E, M));
    localparam logic [MW-1:0] ONE = MW'(fphub_one(E, M));

    logic [MW-1:0] mag;
    logic          sign;

    assign mag  = op[MW-1:0];
    assign sign = op[MW];

    always_comb
        code = mag == INF      ? (sign ? CASE_INF_N  : CASE_INF_P)  :
               mag == '0       ? (sign ? CASE_ZERO_N : CASE_ZERO_P) :
               mag == ONE      ? (sign ? CASE_ONE_N  : CASE_ONE_P)  :
                                 CASE_NONE;

endmodule

// File: rtl/fphub_mult_special_pipe.sv
// fphub_mult_special_pipe: elastic multi-lane special-case resolver for the FPHUB multiplier.
// Stage 0 holds classified codes plus operands; the last stage holds the resolved product.
module fphub_mult_special_pipe
    import fphub_pkg::*;
#(
    parameter int M                = 23,
    parameter int E                = 8,
    parameter int LANES            = 1,
    parameter int STAGES           = 2,
    parameter int INF_ZERO_INVALID = 0,
    parameter int CNT_W            = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*(E+M+1)-1:0]   x,
    input  logic [LANES*(E+M+1)-1:0]   y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*(E+M+1)-1:0]   special_result,
    output logic [LANES-1:0]           special_flag,
    output logic [LANES-1:0]           invalid,
    input  logic                       cnt_clear,
    output logic [CNT_W-1:0]           special_count
);

    localparam int W  = E + M + 1;
    localparam int MW = E + M;
    localparam int P  = STAGES - 1;
    localparam int SW = CNT_W + $clog2(LANES + 1);
    localparam logic [MW-1:0]    INF  = MW'(fphub_inf(E, M));
    localparam logic [MW-1:0]    ZERO = '0;
    localparam logic [CNT_W-1:0] MAXC = '1;

    logic [STAGES-1:0]    v;
    logic [STAGES-1:0]    ld;
    logic [LANES*W-1:0]   sx [P];
    logic [LANES*W-1:0]   sy [P];
    logic [3*LANES-1:0]   scx [P];
    logic [3*LANES-1:0]   scy [P];
    logic [3*LANES-1:0]   cx_in, cy_in;
    logic [LANES*W-1:0]   res_c;
    logic [LANES-1:0]     flag_c, inv_c;
    logic [SW-1:0]        sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        special_case_t cxn, cyn, cx, cy;
        logic [W-1:0]  ox, oy;
        logic          xi, yi, xz, yz, xo, yo;
        fphub_special_classify #(.M(M), .E(E)) u_cx (.op(x[l*W +: W]), .code(cxn));
        fphub_special_classify #(.M(M), .E(E)) u_cy (.op(y[l*W +: W]), .code(cyn));
        assign cx_in[3*l +: 3] = cxn;
        assign cy_in[3*l +: 3] = cyn;
        assign cx = special_case_t'(scx[P-1][3*l +: 3]);
        assign cy = special_case_t'(scy[P-1][3*l +: 3]);
        assign ox = sx[P-1][l*W +: W];
        assign oy = sy[P-1][l*W +: W];
        assign xi = cx == CASE_INF_P  || cx == CASE_INF_N;
        assign yi = cy == CASE_INF_P  || cy == CASE_INF_N;
        assign xz = cx == CASE_ZERO_P || cx == CASE_ZERO_N;
        assign yz = cy == CASE_ZERO_P || cy == CASE_ZERO_N;
        assign xo = cx == CASE_ONE_P  || cx == CASE_ONE_N;
        assign yo = cy == CASE_ONE_P  || cy == CASE_ONE_N;
        // Sign is always the XOR, even when the lane is not special.
        assign res_c[l*W +: W] = {ox[W-1] ^ oy[W-1],
                                  xi || yi ? INF : xz || yz ? ZERO :
                                  xo ? oy[MW-1:0] : yo ? ox[MW-1:0] : ZERO};
        assign flag_c[l] = xi || yi || xz || yz || xo || yo;
        assign inv_c[l]  = INF_ZERO_INVALID != 0 && ((xi && yz) || (xz && yi));
    end

    // A stage loads when empty or when the stage after it can take its content.
    always_comb begin
        logic rdy;
        rdy = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ld[i] = !v[i] || rdy;
            rdy   = ld[i];
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v              <= '0;
            special_result <= '0;
            special_flag   <= '0;
            invalid        <= '0;
            for (int i = 0; i < P; i++) begin
                sx[i]  <= '0;
                sy[i]  <= '0;
                scx[i] <= '0;
                scy[i] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v[0]   <= in_valid;
                sx[0]  <= x;
                sy[0]  <= y;
                scx[0] <= cx_in;
                scy[0] <= cy_in;
            end
            for (int i = 1; i < P; i++) begin
                if (ld[i]) begin
                    v[i]   <= v[i-1];
                    sx[i]  <= sx[i-1];
                    sy[i]  <= sy[i-1];
                    scx[i] <= scx[i-1];
                    scy[i] <= scy[i-1];
                end
            end
            if (ld[STAGES-1]) begin
                v[STAGES-1]    <= v[STAGES-2];
                special_result <= res_c;
                special_flag   <= flag_c;
                invalid        <= inv_c;
            end
        end
    end

    assign sum = SW'(special_count) + SW'($countones(special_flag));

    always_ff @(posedge clk) begin
        if (rst || cnt_clear)
            special_count <= '0;
        else if (out_valid && out_ready)
            special_count <= sum > SW'(MAXC) ? MAXC : sum[CNT_W-1:0];
    end

endmodule

// File: tb/tb_fphub_mult_special_pipe.sv
// tb_fphub_mult_special_pipe: randomized self-checking bench against a magnitude-level reference model.
module tb_fphub_mult_special_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clear;
    logic [31:0]  a_x, a_y, a_res;
    logic [0:0]   a_flag, a_inv;
    logic [3:0]   a_cnt;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clear;
    logic [127:0] b_x, b_y, b_res;
    logic [3:0]   b_flag, b_inv;
    logic [15:0]  b_cnt;

    fphub_mult_special_pipe #(.M(23), .E(8), .LANES(1), .STAGES(2), .INF_ZERO_INVALID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x), .y(a_y),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .special_result(a_res),
        .special_flag(a_flag), .invalid(a_inv), .cnt_clear(a_cnt_clear), .special_count(a_cnt));

    fphub_mult_special_pipe #(.M(23), .E(8), .LANES(4), .STAGES(3), .INF_ZERO_INVALID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .y(b_y),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .special_result(b_res),
        .special_flag(b_flag), .invalid(b_inv), .cnt_clear(b_cnt_clear), .special_count(b_cnt));

    int total = 0, passed = 0, fails = 0;
    int a_model_cnt = 0, b_model_cnt = 0;
    logic [127:0] bq_res[$];
    logic [3:0]   bq_flag[$], bq_inv[$];
    logic [31:0]  tx [10][4], ty [10][4];

    // Reference: {invalid, flag, result} from the precedence rules on raw magnitudes.
    function automatic logic [33:0] ref_mul(input logic [31:0] xv, input logic [31:0] yv, input bit iz);
        logic [30:0] mx, my, mag;
        bit xi, yi, xz, yz, xo, yo;
        mx = xv[30:0];
        my = yv[30:0];
        xi = mx == 31'h7FFFFFFF; yi = my == 31'h7FFFFFFF;
        xz = mx == 31'h0;        yz = my == 31'h0;
        xo = mx == 31'h40000000; yo = my == 31'h40000000;
        if (xi || yi)      mag = 31'h7FFFFFFF;
        else if (xz || yz) mag = 31'h0;
        else if (xo)       mag = my;
        else if (yo)       mag = mx;
        else               mag = 31'h0;
        return {iz && ((xi && yz) || (xz && yi)), xi || yi || xz || yz || xo || yo, xv[31] ^ yv[31], mag};
    endfunction

    function automatic logic [31:0] rand_op(input bit force_special);
        int k;
        logic [30:0] mag;
        k = force_special ? $urandom_range(0, 2) : $urandom_range(0, 4);
        mag = 31'($urandom);
        if (k == 0)      mag = 31'h7FFFFFFF;
        else if (k == 1) mag = 31'h0;
        else if (k == 2) mag = 31'h40000000;
        else if (k == 4) mag = 31'h40000000 | (31'd1 << $urandom_range(0, 22));
        return {1'($urandom), mag};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input logic [31:0] xv, input logic [31:0] yv, input bit clr);
        logic [33:0] e;
        int lat, t;
        e = ref_mul(xv, yv, 1'b1);
        a_x = xv; a_y = yv; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        chk("a_in_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!a_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        chk("a_latency", lat, 2);
        chk("a_result", a_res, e[31:0]);
        chk("a_flag", a_flag, e[32]);
        chk("a_invalid", a_inv, e[33]);
        a_cnt_clear = clr;
        @(posedge clk); #1;
        a_cnt_clear = 1'b0;
        t = a_model_cnt + int'(e[32]);
        a_model_cnt = clr ? 0 : (t > 15 ? 15 : t);
        chk("a_count", a_cnt, a_model_cnt);
    endtask

    task automatic load_b(input int n);
        for (int l = 0; l < 4; l++) begin
            b_x[l*32 +: 32] = tx[n][l];
            b_y[l*32 +: 32] = ty[n][l];
        end
    endtask

    task automatic step_b(output bit acc);
        logic [127:0] r;
        logic [3:0]   f, iv;
        logic [33:0]  e;
        int t;
        @(negedge clk);
        chk("b_in_ready", b_in_ready, b_out_ready || bq_res.size() < 3);
        if (b_out_valid && b_out_ready) begin
            if (bq_res.size() == 0) chk("b_extra_out", b_out_valid, 0);
            else begin
                r = bq_res.pop_front(); f = bq_flag.pop_front(); iv = bq_inv.pop_front();
                chk("b_result", b_res, r);
                chk("b_flag", b_flag, f);
                chk("b_invalid", b_inv, iv);
                t = b_model_cnt + $countones(f);
                b_model_cnt = t > 65535 ? 65535 : t;
            end
        end
        acc = b_in_valid && b_in_ready;
        if (acc) begin
            for (int l = 0; l < 4; l++) begin
                e = ref_mul(b_x[l*32 +: 32], b_y[l*32 +: 32], 1'b0);
                r[l*32 +: 32] = e[31:0];
                f[l] = e[32];
                iv[l] = e[33];
            end
            bq_res.push_back(r); bq_flag.push_back(f); bq_inv.push_back(iv);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int sent, k;
        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_cnt_clear = 0; a_x = 0; a_y = 0;
        b_in_valid = 0; b_out_ready = 0; b_cnt_clear = 0; b_x = 0; b_y = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_a_out_valid", a_out_valid, 0);
        chk("reset_a_result", a_res, 0);
        chk("reset_a_flag", a_flag, 0);
        chk("reset_a_invalid", a_inv, 0);
        chk("reset_a_count", a_cnt, 0);
        chk("reset_a_in_ready", a_in_ready, 1);
        chk("reset_b_out_valid", b_out_valid, 0);
        chk("reset_b_result", b_res, 0);
        chk("reset_b_in_ready", b_in_ready, 1);

        run_a(32'h7FFFFFFF, 32'hC0000000, 1'b0);
        run_a(32'h40000000, 32'h3F123456, 1'b0);
        run_a(32'hBF123456, 32'hC0000000, 1'b0);
        run_a(32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_a(32'h3F800001, 32'h40800000, 1'b0);
        for (int i = 0; i < 16; i++) run_a(rand_op(1'b1), rand_op(1'b0), 1'b0);
        chk("a_count_saturated", a_cnt, 15);
        run_a(32'h7FFFFFFF, 32'h00000000, 1'b1);
        chk("a_count_cleared", a_cnt, 0);

        tx[0] = '{32'h7FFFFFFF, 32'h40000000, 32'hBF123456, 32'hFFFFFFFF};
        ty[0] = '{32'hC0000000, 32'h3F123456, 32'hC0000000, 32'h00000000};
        tx[1] = '{32'h3F800001, rand_op(1'b0), rand_op(1'b0), rand_op(1'b0)};
        ty[1] = '{32'h40800000, rand_op(1'b0), rand_op(1'b0), rand_op(1'b0)};
        for (int n = 2; n < 10; n++)
            for (int l = 0; l < 4; l++) begin
                tx[n][l] = rand_op(1'b0);
                ty[n][l] = rand_op(1'b0);
            end

        sent = 0; k = 0;
        load_b(0);
        b_in_valid = 1'b1;
        while ((sent < 10 || bq_res.size() > 0) && k < 200) begin
            b_out_ready = !(k >= 4 && k < 9);
            step_b(acc);
            if (acc) sent++;
            b_in_valid = sent < 10;
            if (sent < 10) load_b(sent);
            k++;
        end
        chk("b_all_sent", sent, 10);
        chk("b_drained", bq_res.size(), 0);
        chk("b_count", b_cnt, b_model_cnt);

        b_out_ready = 1'b0;
        load_b(3);
        b_in_valid = 1'b1;
        step_b(acc);
        load_b(4);
        step_b(acc);
        b_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bq_res.delete(); bq_flag.delete(); bq_inv.delete();
        b_model_cnt = 0;
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_result", b_res, 0);
        chk("rst_b_flag", b_flag, 0);
        chk("rst_b_invalid", b_inv, 0);
        chk("rst_b_count", b_cnt, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        chk("rst_a_count", a_cnt, 0);
        b_out_ready = 1'b1;
        repeat (5) step_b(acc);
        chk("rst_b_no_stale", b_out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fphub_mult_special_pipe.md
# fphub_mult_special_pipe

Pipelined, multi-lane special-case unit for the FPHUB multiplier. It classifies both operands of each lane itself into the shared special-case codes and resolves the special product: ±inf, ±0, ±1 pass-through, or "no special case". Each lane also gets a special flag and an invalid (inf×0) flag, and the unit keeps a saturating event counter. It sits in parallel with the mantissa/exponent datapath. The top-level mux selects `special_result` whenever `special_flag` is set.

## Interface
Parameters:
- `M`, 23: mantissa width.
- `E`, 8: exponent width.
- `LANES`, 1: independent operand pairs per transaction.
- `STAGES`, 2: register stages; minimum 2; stage 1 is classify, the last stage is resolve, extras are pass-through.
- `INF_ZERO_INVALID`, 0: 1 raises `invalid` on inf×0.
- `CNT_W`, 16: width of `special_count`.

Ports:
- `clk`, in, 1: clock. One clock domain; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `in_valid`, in, 1: input transaction valid.
- `in_ready`, out, 1: unit accepts an input this cycle.
- `x`, in, LANES*(E+M+1): X operands; lane i is at [i*(E+M+1) +: E+M+1].
- `y`, in, LANES*(E+M+1): Y operands, same packing.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `special_result`, out, LANES*(E+M+1): resolved product per lane.
- `special_flag`, out, LANES: lane result is special.
- `invalid`, out, LANES: inf×0 detected (only when `INF_ZERO_INVALID`=1).
- `cnt_clear`, in, 1: synchronous clear of `special_count`.
- `special_count`, out, CNT_W: saturating count of special lane results delivered.

## Operation
- Classification per operand, with exp = bits [E+M-1:M] and mant = bits [M-1:0]:
  - inf: exp all ones and mant all ones.
  - zero: exp and mant all zero.
  - one: exp = 1 followed by zeros (10…0) and mant = 0.
  - The sign bit selects the _P or _N code. Anything else is CASE_NONE.
- Codes: NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6. Code width is 3.
- Resolution precedence per lane:
  1. Either operand inf → magnitude all ones.
  2. Else either zero → magnitude 0.
  3. Else X is ±1 → Y.
  4. Else Y is ±1 → X.
  5. Else magnitude 0 with `special_flag`=0.
- Sign: the result MSB is always x_sign ^ y_sign, including the non-special case.
- `special_flag` is 1 for precedence cases 1–4 and 0 otherwise.
- inf×0 resolves to inf (inf wins). `invalid`=1 only when `INF_ZERO_INVALID`=1.
- `special_count` increments by popcount(`special_flag`) on each output handshake (`out_valid` && `out_ready`) and saturates at 2^CNT_W-1.
- `cnt_clear` has priority over an increment in the same cycle.

## Timing
- Elastic pipeline of STAGES registers. Each stage holds a valid bit and loads when it is empty or when it advances downstream.
- `in_ready` = !v[0] || (stage 0 advances this cycle). This is combinational from `out_ready` through the chain.
- Latency: STAGES cycles from input handshake to `out_valid`, with `out_ready` held high. Throughput is 1 transaction/cycle.
- `out_ready`=0: the pipeline fills. After STAGES accepted transactions `in_ready` drops. No data loss or duplication; order is preserved.
- Output data is stable while `out_valid` && !`out_ready`.
- Reset:
  - All valids clear; in-flight transactions are discarded.
  - `out_valid`=0, `special_result`=0, `special_flag`=0, `invalid`=0, `special_count`=0.
  - `in_ready`=1 from the first cycle after reset deasserts.
- Simultaneous input and output handshakes at a full pipe are allowed; occupancy stays unchanged.

## Structure
- Shared package `fphub_pkg`:
  - `special_case_t` enum with the 7 codes above.
  - `SPECIAL_CASES`=7 constant.
  - Functions `fphub_inf(E,M)`, `fphub_one(E,M)`, which return the magnitude patterns.
- Sub-module `fphub_special_classify`: combinational, one operand → `special_case_t`. The block instantiates 2×LANES of them in stage 1.
- Resolve logic and pipeline registers live in the top module. The per-stage payload is the codes plus the operands.

## Test plan
- M=23/E=8: x=0x7FFFFFFF, y=0xC0000000 → after 2 cycles `special_result`=0xFFFFFFFF, `special_flag`=1, `invalid`=0.
- x=0x40000000, y=0x3F123456 → 0x3F123456, flag 1. Also x=0xBF123456, y=0xC0000000 → 0x3F123456, flag 1.
- x=0xFFFFFFFF, y=0x00000000:
  - With INF_ZERO_INVALID=1 → 0xFFFFFFFF, invalid=1.
  - With 0 → same result, invalid=0.
- x=0x3F800001, y=0x40800000 → flag 0, result 0x00000000.
- LANES=4, STAGES=3: 10 back-to-back transactions with `out_ready` low for 5 cycles mid-stream.
  - `in_ready` drops after 3 held transactions.
  - All 10 results arrive in order, with no duplicates.
- Mixed behaviour:
  - Assert `rst` for one cycle with 2 transactions in flight → `out_valid`=0 next cycle and no stale output afterwards.
  - CNT_W=4: 20 special lanes → count saturates at 15.
  - `cnt_clear` asserted together with a handshake → count 0.
